// File: rtl/keypad_pkg.sv
// Keypad decoder shared types: FSM states, coordinate-to-digit keymap, one-hot helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kd_state_t;

    // Indexed by {r,s}; rows read "1 2 3 A", "4 5 6 B", "7 8 9 C", "E 0 F D".
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic onehot_valid(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Scanner-to-decoder bundle: scan/sense coordinates in, decoded key events and digit history out.
// Latency: wiring only.
// Backpressure: none; outputs are pulses and held levels.
interface keypad_decoder_if;
    logic [3:0] scan_q;
    logic [3:0] sense_q;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_held;

    modport master (
        output scan_q, sense_q,
        input  key_valid, key_code, digit_new, digit_old, key_held
    );

    modport slave (
        input  scan_q, sense_q,
        output key_valid, key_code, digit_new, digit_old, key_held
    );
endinterface

// File: rtl/keypad_decoder.sv
// Debounces a single-key press, decodes it to a hex digit and keeps a two-digit history.
// Latency: key_valid D+1 edges after the first sample of a stable key; all outputs registered.
// Backpressure: none; one key_valid pulse per accepted press, no rollover.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 480_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    keypad_decoder_if.slave  kif
);

    // Counter observes 0..D-1 on the D counting edges; the next matching edge sees D and commits.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES);

    kd_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       coord_q;
    logic             key_valid_q;
    logic [3:0]       key_code_q;
    logic [3:0]       digit_new_q;
    logic [3:0]       digit_old_q;
    logic             key_held_q;

    logic             cand_vld;
    logic [3:0]       cand_coord;
    logic             match;

    assign cand_vld   = onehot_valid(kif.scan_q) && onehot_valid(kif.sense_q);
    assign cand_coord = {onehot_idx(kif.sense_q), onehot_idx(kif.scan_q)};
    assign match      = cand_vld && (cand_coord == coord_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            coord_q     <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            digit_new_q <= '0;
            digit_old_q <= '0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand_vld) begin
                        coord_q <= cand_coord;
                        cnt_q   <= '0;
                        state_q <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!match) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_TERM) begin
                        state_q     <= HELD;
                        key_valid_q <= 1'b1;
                        key_code_q  <= KEYMAP[coord_q];
                        digit_new_q <= KEYMAP[coord_q];
                        digit_old_q <= digit_new_q;
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!match) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                    end
                end
                REL_DB: begin
                    if (match) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_TERM) begin
                        state_q    <= IDLE;
                        key_held_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign kif.key_valid = key_valid_q;
    assign kif.key_code  = key_code_q;
    assign kif.digit_new = digit_new_q;
    assign kif.digit_old = digit_old_q;
    assign kif.key_held  = key_held_q;

endmodule
